// File: rtl/sm83_alu_pkg.sv
// Shared opcode encoding, flag bit positions and per-opcode ALU control decode
// for the sm83 nibble-serial ALU sequencer.
package sm83_alu_pkg;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_H = 1;
   localparam int FLAG_C = 0;

   typedef enum logic [3:0] {
      OP_ADD = 4'h0,
      OP_ADC = 4'h1,
      OP_SUB = 4'h2,
      OP_SBC = 4'h3,
      OP_AND = 4'h4,
      OP_XOR = 4'h5,
      OP_OR  = 4'h6,
      OP_CP  = 4'h7,
      OP_INC = 4'h8,
      OP_DEC = 4'h9,
      OP_RLC = 4'hA,
      OP_RRC = 4'hB,
      OP_RL  = 4'hC,
      OP_RR  = 4'hD,
      OP_SLA = 4'hE,
      OP_SRL = 4'hF
   } alu_op_t;

   // r/s/v drive the ALU's no_carry_out/force_carry/ignore_carry pins.
   typedef struct packed {
      logic r;
      logic s;
      logic v;
      logic negate;
      logic is_sub;
      logic is_logic;
      logic is_shift;
   } alu_ctrl_t;

   function automatic alu_ctrl_t op_ctrl(input alu_op_t op);
      alu_ctrl_t c;
      c = '0;
      case (op)
         OP_SUB, OP_SBC, OP_CP, OP_DEC: begin
            c.negate = 1'b1;
            c.is_sub = 1'b1;
         end
         OP_AND: begin
            c.s        = 1'b1;
            c.is_logic = 1'b1;
         end
         OP_XOR: begin
            c.r        = 1'b1;
            c.is_logic = 1'b1;
         end
         OP_OR: begin
            c.r        = 1'b1;
            c.v        = 1'b1;
            c.is_logic = 1'b1;
         end
         OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRL: begin
            c.is_shift = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/sm83_alu_seq.sv
// Micro-sequencer for the nibble-serial sm83_alu: loads operands, runs the low
// and high nibble passes (or a single shift pass) and reports result and flags.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | ready for a request; all ALU controls low
// ST_LD_A  | operand A onto the ALU bus, latched into the A register
// ST_LD_B  | operand B (or zero for INC/DEC) latched into the B register
// ST_LO    | low nibble pass; low carry captured at the closing edge
// ST_HI    | high nibble pass; result byte and flags captured
// ST_SHIFT | single-cycle shift through the ALU shifter; result captured
module sm83_alu_seq
   import sm83_alu_pkg::*;
#(
   parameter int ALU_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  alu_op_t                  req_op,
   input  logic [2*ALU_WIDTH-1:0]   req_a,
   input  logic [2*ALU_WIDTH-1:0]   req_b,
   input  logic [3:0]               req_flags,
   output logic                     res_valid,
   output logic [2*ALU_WIDTH-1:0]   res_data,
   output logic [3:0]               res_flags,
   output logic                     res_wb,
   output logic [2*ALU_WIDTH-1:0]   alu_din,
   output logic                     alu_load_a,
   output logic                     alu_load_b,
   output logic                     alu_load_b_zero,
   output logic                     alu_shift_l,
   output logic                     alu_shift_r,
   output logic                     alu_shift_in,
   output logic                     alu_carry_in,
   output logic                     alu_result_oe,
   output logic                     alu_shift_oe,
   output logic                     alu_negate,
   output logic                     alu_op_low,
   output logic                     alu_op_b_high,
   output logic                     alu_no_carry_out,
   output logic                     alu_force_carry,
   output logic                     alu_ignore_carry,
   input  logic [2*ALU_WIDTH-1:0]   alu_dout,
   input  logic                     alu_carry,
   input  logic                     alu_zero,
   input  logic                     alu_shift_dbh,
   input  logic                     alu_shift_dbl
);

   localparam int WORD_SIZE = 2 * ALU_WIDTH;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LD_A,
      ST_LD_B,
      ST_LO,
      ST_HI,
      ST_SHIFT
   } state_t;

   state_t                 state_q;
   alu_op_t                op_q;
   logic [WORD_SIZE-1:0]   a_q;
   logic [WORD_SIZE-1:0]   b_q;
   logic                   cflag_q;
   logic                   c_lo_q;
   logic                   res_valid_q;
   logic [WORD_SIZE-1:0]   res_data_q;
   logic [3:0]             res_flags_q;
   logic                   res_wb_q;

   alu_ctrl_t              ctrl;
   alu_ctrl_t              req_ctrl;
   logic                   is_incdec;
   logic                   is_left;
   logic                   cin_lo;
   logic                   shift_in_bit;
   logic                   half_d;
   logic                   carry_d;
   logic                   unused_ok;

   assign ctrl      = op_ctrl(op_q);
   assign req_ctrl  = op_ctrl(req_op);
   assign is_incdec = (op_q == OP_INC) || (op_q == OP_DEC);
   assign is_left   = (op_q == OP_RLC) || (op_q == OP_RL) || (op_q == OP_SLA);

   // Only the incoming carry matters; Z/N/H are always recomputed.
   assign unused_ok = ^{req_flags[FLAG_Z], req_flags[FLAG_N], req_flags[FLAG_H],
                        req_ctrl.r, req_ctrl.s, req_ctrl.v, req_ctrl.negate,
                        req_ctrl.is_sub, req_ctrl.is_logic, ctrl.is_shift};

   always_comb begin
      cin_lo = 1'b0;
      case (op_q)
         OP_ADC:                        cin_lo = cflag_q;
         OP_SUB, OP_CP, OP_AND, OP_INC: cin_lo = 1'b1;
         OP_SBC:                        cin_lo = ~cflag_q;
         default:                       cin_lo = 1'b0;
      endcase
   end

   always_comb begin
      shift_in_bit = 1'b0;
      case (op_q)
         OP_RLC:       shift_in_bit = a_q[WORD_SIZE-1];
         OP_RRC:       shift_in_bit = a_q[0];
         OP_RL, OP_RR: shift_in_bit = cflag_q;
         default:      shift_in_bit = 1'b0;
      endcase
   end

   // Subtraction runs as A + ~B + 1, so carries out are inverted borrows.
   assign half_d  = ctrl.is_logic ? ctrl.s : (c_lo_q ^ ctrl.is_sub);
   assign carry_d = ctrl.is_logic ? 1'b0 :
                    is_incdec     ? cflag_q : (alu_carry ^ ctrl.is_sub);

   always_comb begin
      alu_din          = '0;
      alu_load_a       = 1'b0;
      alu_load_b       = 1'b0;
      alu_load_b_zero  = 1'b0;
      alu_shift_l      = 1'b0;
      alu_shift_r      = 1'b0;
      alu_shift_in     = 1'b0;
      alu_carry_in     = 1'b0;
      alu_result_oe    = 1'b0;
      alu_shift_oe     = 1'b0;
      alu_negate       = 1'b0;
      alu_op_low       = 1'b0;
      alu_op_b_high    = 1'b0;
      alu_no_carry_out = 1'b0;
      alu_force_carry  = 1'b0;
      alu_ignore_carry = 1'b0;
      case (state_q)
         ST_LD_A: begin
            alu_din      = a_q;
            alu_shift_oe = 1'b1;
            alu_load_a   = 1'b1;
         end
         ST_LD_B: begin
            alu_din         = b_q;
            alu_shift_oe    = 1'b1;
            alu_load_b      = ~is_incdec;
            alu_load_b_zero = is_incdec;
         end
         ST_LO: begin
            alu_op_low       = 1'b1;
            alu_carry_in     = cin_lo;
            alu_negate       = ctrl.negate;
            alu_no_carry_out = ctrl.r;
            alu_force_carry  = ctrl.s;
            alu_ignore_carry = ctrl.v;
         end
         ST_HI: begin
            alu_op_b_high    = 1'b1;
            alu_carry_in     = c_lo_q;
            alu_result_oe    = 1'b1;
            alu_negate       = ctrl.negate;
            alu_no_carry_out = ctrl.r;
            alu_force_carry  = ctrl.s;
            alu_ignore_carry = ctrl.v;
         end
         ST_SHIFT: begin
            alu_din      = a_q;
            alu_shift_oe = 1'b1;
            alu_shift_l  = is_left;
            alu_shift_r  = ~is_left;
            alu_shift_in = shift_in_bit;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_ADD;
         a_q         <= '0;
         b_q         <= '0;
         cflag_q     <= 1'b0;
         c_lo_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_flags_q <= '0;
         res_wb_q    <= 1'b0;
      end else begin
         res_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  op_q    <= req_op;
                  a_q     <= req_a;
                  b_q     <= req_b;
                  cflag_q <= req_flags[FLAG_C];
                  state_q <= req_ctrl.is_shift ? ST_SHIFT : ST_LD_A;
               end
            end
            ST_LD_A: state_q <= ST_LD_B;
            ST_LD_B: state_q <= ST_LO;
            ST_LO: begin
               c_lo_q  <= alu_carry;
               state_q <= ST_HI;
            end
            ST_HI: begin
               res_valid_q <= 1'b1;
               res_data_q  <= alu_dout;
               res_flags_q <= {alu_zero, ctrl.is_sub, half_d, carry_d};
               res_wb_q    <= (op_q != OP_CP);
               state_q     <= ST_IDLE;
            end
            ST_SHIFT: begin
               res_valid_q <= 1'b1;
               res_data_q  <= alu_dout;
               res_flags_q <= {alu_zero, 1'b0, 1'b0,
                               is_left ? alu_shift_dbh : alu_shift_dbl};
               res_wb_q    <= 1'b1;
               state_q     <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_flags = res_flags_q;
   assign res_wb    = res_wb_q;

endmodule

// File: tb/tb_sm83_alu_seq.sv
// Bench for sm83_alu_seq: a behavioural nibble ALU answers the control pins,
// and results are compared with an instruction-level Z/N/H/C reference.
module tb_sm83_alu_seq;
   import sm83_alu_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   alu_op_t    req_op;
   logic [7:0] req_a, req_b;
   logic [3:0] req_flags;
   logic       res_valid;
   logic [7:0] res_data;
   logic [3:0] res_flags;
   logic       res_wb;
   logic [7:0] alu_din;
   logic       alu_load_a, alu_load_b, alu_load_b_zero;
   logic       alu_shift_l, alu_shift_r, alu_shift_in, alu_carry_in;
   logic       alu_result_oe, alu_shift_oe, alu_negate, alu_op_low, alu_op_b_high;
   logic       alu_no_carry_out, alu_force_carry, alu_ignore_carry;
   logic [7:0] alu_dout;
   logic       alu_carry, alu_zero, alu_shift_dbh, alu_shift_dbl;

   int n_assert = 0;
   int n_fail   = 0;

   sm83_alu_seq #(.ALU_WIDTH(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_flags(req_flags),
      .res_valid(res_valid), .res_data(res_data), .res_flags(res_flags), .res_wb(res_wb),
      .alu_din(alu_din), .alu_load_a(alu_load_a), .alu_load_b(alu_load_b),
      .alu_load_b_zero(alu_load_b_zero), .alu_shift_l(alu_shift_l), .alu_shift_r(alu_shift_r),
      .alu_shift_in(alu_shift_in), .alu_carry_in(alu_carry_in), .alu_result_oe(alu_result_oe),
      .alu_shift_oe(alu_shift_oe), .alu_negate(alu_negate), .alu_op_low(alu_op_low),
      .alu_op_b_high(alu_op_b_high), .alu_no_carry_out(alu_no_carry_out),
      .alu_force_carry(alu_force_carry), .alu_ignore_carry(alu_ignore_carry),
      .alu_dout(alu_dout), .alu_carry(alu_carry), .alu_zero(alu_zero),
      .alu_shift_dbh(alu_shift_dbh), .alu_shift_dbl(alu_shift_dbl)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: operands latch on negedge, low result latches on posedge.
   logic [7:0] m_a = 8'h00, m_b = 8'h00, m_shift;
   logic [3:0] m_lo = 4'h0, n_a, n_b, n_res;
   logic [4:0] n_sum;
   logic       n_cy;

   always @(negedge clk) begin
      if (alu_load_a)      m_a <= alu_din;
      if (alu_load_b)      m_b <= alu_din;
      if (alu_load_b_zero) m_b <= 8'h00;
   end

   always @(posedge clk) begin
      if (alu_op_low) m_lo <= n_res;
   end

   always_comb begin
      n_a = alu_op_low ? m_a[3:0] : m_a[7:4];
      n_b = alu_op_b_high ? m_b[7:4] : m_b[3:0];
      if (alu_negate) n_b = ~n_b;
      n_sum = {1'b0, n_a} + {1'b0, n_b} + {4'b0000, alu_carry_in};
      if (alu_no_carry_out) begin
         n_res = alu_ignore_carry ? (n_a | n_b) : (n_a ^ n_b);
         n_cy  = 1'b0;
      end else if (alu_force_carry) begin
         n_res = n_a & n_b;
         n_cy  = 1'b0;
      end else begin
         n_res = n_sum[3:0];
         n_cy  = n_sum[4];
      end
      if (alu_shift_l)      m_shift = {alu_din[6:0], alu_shift_in};
      else if (alu_shift_r) m_shift = {alu_shift_in, alu_din[7:1]};
      else                  m_shift = alu_din;
      if (alu_result_oe)     alu_dout = {n_res, m_lo};
      else if (alu_shift_oe) alu_dout = m_shift;
      else                   alu_dout = 8'h00;
      alu_zero      = (alu_dout == 8'h00);
      alu_carry     = n_cy;
      alu_shift_dbh = alu_din[7];
      alu_shift_dbl = alu_din[0];
   end

   // Instruction-level reference: returns {wb, Z, N, H, C, data}.
   function automatic logic [12:0] ref_op(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [3:0] f);
      int ia, ib, ic, r;
      logic [7:0] d;
      logic n, h, cy;
      ia = int'(a); ib = int'(b); ic = int'(f[0]);
      n = 1'b0; h = 1'b0; cy = 1'b0; r = 0; d = 8'h00;
      case (op)
         4'h0: begin r = ia + ib;      h = (ia % 16 + ib % 16) > 15;      cy = r > 255; end
         4'h1: begin r = ia + ib + ic; h = (ia % 16 + ib % 16 + ic) > 15; cy = r > 255; end
         4'h2, 4'h7: begin r = ia - ib; h = (ia % 16) < (ib % 16); cy = ia < ib; n = 1'b1; end
         4'h3: begin r = ia - ib - ic; h = (ia % 16) < (ib % 16 + ic); cy = ia < ib + ic; n = 1'b1; end
         4'h4: begin r = ia & ib; h = 1'b1; end
         4'h5: r = ia ^ ib;
         4'h6: r = ia | ib;
         4'h8: begin r = ia + 1; h = (ia % 16) == 15; cy = f[0]; end
         4'h9: begin r = ia - 1; h = (ia % 16) == 0;  cy = f[0]; n = 1'b1; end
         default: r = 0;
      endcase
      d = 8'(r);
      case (op)
         4'hA: begin d = {a[6:0], a[7]}; cy = a[7]; end
         4'hB: begin d = {a[0], a[7:1]}; cy = a[0]; end
         4'hC: begin d = {a[6:0], f[0]}; cy = a[7]; end
         4'hD: begin d = {f[0], a[7:1]}; cy = a[0]; end
         4'hE: begin d = {a[6:0], 1'b0}; cy = a[7]; end
         4'hF: begin d = {1'b0, a[7:1]}; cy = a[0]; end
         default: ;
      endcase
      return {op != 4'h7, d == 8'h00, n, h, cy, d};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] ctrl_bus();
      return {alu_din, alu_load_a, alu_load_b, alu_load_b_zero, alu_shift_l, alu_shift_r,
              alu_shift_in, alu_carry_in, alu_result_oe, alu_shift_oe, alu_negate,
              alu_op_low, alu_op_b_high, alu_no_carry_out, alu_force_carry, alu_ignore_carry,
              1'b0};
   endfunction

   task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] f);
      logic [12:0] exp;
      int cyc;
      logic seen;
      exp = ref_op(op, a, b, f);
      check("ready_idle", req_ready, 1);
      req_op = alu_op_t'(op); req_a = a; req_b = b; req_flags = f; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_a = 8'($urandom); req_b = 8'($urandom); req_flags = 4'($urandom);
      check("ready_busy", req_ready, 0);
      check("first_din", alu_din, a);
      check("first_oe", alu_shift_oe, 1);
      cyc = 1; seen = 1'b0;
      while (!seen && cyc < 12) begin
         @(posedge clk); #1;
         cyc++;
         if (res_valid === 1'b1) seen = 1'b1;
      end
      check("res_seen", seen, 1);
      check("latency", cyc, (op >= 4'hA) ? 2 : 5);
      check("res_data", res_data, exp[7:0]);
      check("res_flags", res_flags, exp[11:8]);
      check("res_wb", res_wb, exp[12]);
   endtask

   initial begin
      logic seen;
      reset = 1'b1; req_valid = 1'b0; req_op = OP_ADD;
      req_a = 8'h00; req_b = 8'h00; req_flags = 4'h0;
      #2;
      check("rst_valid", res_valid, 0);
      check("rst_data", res_data, 0);
      check("rst_flags", res_flags, 0);
      check("rst_wb", res_wb, 0);
      check("rst_ctrl", ctrl_bus(), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      run_op(4'h0, 8'h3A, 8'hC6, 4'h0);   // ADD
      run_op(4'h7, 8'h3C, 8'h40, 4'h0);   // CP
      run_op(4'h4, 8'h5A, 8'h3F, 4'h0);   // AND
      run_op(4'h5, 8'hFF, 8'hFF, 4'h0);   // XOR
      run_op(4'h9, 8'h10, 8'h00, 4'h1);   // DEC
      run_op(4'h8, 8'hFF, 8'h00, 4'h0);   // INC
      run_op(4'hA, 8'h85, 8'h00, 4'h0);   // RLC
      run_op(4'hF, 8'h8B, 8'h00, 4'h0);   // SRL
      run_op(4'hD, 8'h01, 8'h00, 4'h1);   // RR
      run_op(4'h3, 8'h10, 8'h0F, 4'h1);   // SBC with borrow in
      run_op(4'h1, 8'h0F, 8'hF0, 4'h1);   // ADC chaining into both carries
      @(posedge clk); #1;
      check("pulse_end", res_valid, 0);
      check("idle_ctrl", ctrl_bus(), 0);

      // Reset in the low-nibble pass abandons the operation.
      req_op = OP_ADD; req_a = 8'h12; req_b = 8'h34; req_flags = 4'h0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("lo_op_low", alu_op_low, 1);
      reset = 1'b1;
      #1;
      check("midrst_ctrl", ctrl_bus(), 0);
      check("midrst_ready", req_ready, 1);
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (res_valid !== 1'b0) seen = 1'b1;
      end
      reset = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (res_valid !== 1'b0) seen = 1'b1;
      end
      check("midrst_no_valid", seen, 0);
      run_op(4'h0, 8'h01, 8'h01, 4'h0);

      for (int i = 0; i < 300; i++) begin
         run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 4'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
